nor_power_meter: RTL and testbench
==================================

Name: nor_power_meter

Overview:
Downstream measurement stage for the single-output gate cells (NOR and similar): consumes the gate output Q. It counts 0->1 and 1->0 transitions over a programmable window of clock cycles and accumulates a weighted energy figure. It reports the count and energy through a valid/ack handshake. It replaces free-running testbench counters with a synthesizable, windowed, cycle-exact meter.

Parameters:
CNT_W, 16, width of toggle counter and window length
PWR_W, 24, width of energy accumulator
E_RISE, 3, energy units added per 0->1 transition
E_FALL, 2, energy units added per 1->0 transition

Ports:
clk  input  1  single clock, all state updates on rising edge
reset_L  input  1  asynchronous, active-low reset
din  input  1  gate output Q under measurement
start  input  1  request a measurement; accepted only in IDLE
window_len  input  CNT_W  number of sample edges in the window, latched on start acceptance
ack  input  1  consumer acknowledges results; meaningful only while valid=1
busy  output  1  high in MEASURE
valid  output  1  high in REPORT; results stable while high
toggle_count  output  CNT_W  transitions counted in the last window
energy  output  PWR_W  weighted energy of the last window
sat  output  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset (reset_L=0, asynchronous): state=IDLE; busy=0, valid=0, toggle_count=0, energy=0, sat=0; din_q=0, remaining=0.
- din_q: register of din. Updated every edge in every state, so entering MEASURE never sees a stale edge.
- Transition at an edge: din != din_q. Rise: din=1. Fall: din=0.
- IDLE: if start=1, then clear toggle_count, energy and sat. Latch remaining=window_len. Go to MEASURE, or to REPORT directly if window_len=0 (zero results).
- MEASURE (busy=1): each edge evaluates one transition. Rise adds 1 to toggle_count and E_RISE to energy. Fall adds 1 to toggle_count and E_FALL to energy. remaining decrements. The edge that brings remaining to 0 counts its own transition and moves to REPORT.
- Latency: start accepted at edge k gives sample edges k+1..k+N. valid=1 after edge k+N.
- REPORT (valid=1): outputs frozen. ack=1 at an edge returns to IDLE with valid=0. Results stay readable in IDLE until the next accepted start.
- start is ignored in MEASURE and REPORT. It is not queued. Simultaneous start+ack in REPORT honors ack only.
- ack outside REPORT is ignored.
- Arithmetic: toggle_count saturates at 2^CNT_W-1. energy saturates at 2^PWR_W-1. There is no wrap-around.
- window_len changes after acceptance have no effect.
- reset_L low mid-MEASURE or mid-REPORT: immediate return to reset values. Partial results are discarded.
- States encoded in 2 bits. Code 3 is unreachable and recovers to IDLE on the next edge.

Optional Feature:
Macro SAT_FLAG_EN.
- Defined: sat goes 1 at the edge where either accumulator would exceed its maximum. It stays 1 until the next accepted start or reset. It is visible in MEASURE and REPORT.
- Undefined: no overflow detection logic. sat is tied 0. Saturation arithmetic is unchanged.

Test Plan:
- Reset: hold reset_L=0 with din toggling -> all outputs 0, state IDLE. Release -> still idle, valid=0.
- Four-phase NOR stimulus: window_len=8; din sequence 1,0,0,0,0,1,0,0 after start (din_q=0 before) -> toggle_count=4 (2 rises, 2 falls), energy=10, valid at start edge+8.
- window_len=0 with start -> valid next cycle, toggle_count=0, energy=0. ack -> IDLE.
- Back-pressure: hold ack=0 for 20 cycles in REPORT while din toggles and start pulses -> outputs unchanged, no new measurement. Start+ack together -> IDLE only.
- Saturation: CNT_W=4, window_len=15, din toggling every edge with SAT_FLAG_EN defined -> toggle_count=15; energy = 8*E_RISE + 7*E_FALL = 38 (first sampled edge is a rise, din_q=0 before); sat=0. Repeat with PWR_W=5 -> energy=31, sat=1. Without SAT_FLAG_EN, sat=0.
- Reset mid-MEASURE after 3 of 10 edges -> outputs 0 immediately. New start with window_len=2 and one toggle -> toggle_count=1.

Source files
------------

// File: rtl/nor_power_meter.sv
// -----------------------------------------------------------------------------
// nor_power_meter
//
// Windowed transition / energy meter for a single-output gate cell (NOR and
// similar).  It watches the gate output Q on `din` and, for a programmable
// number of sample edges, does the following:
//   - counts 0->1 and 1->0 transitions, and
//   - accumulates a weighted energy figure (E_RISE per rise, E_FALL per fall).
// Results are presented through a valid/ack handshake.
//
// Both accumulators saturate at their all-ones value and never wrap.
//
// Optional feature (compile-time macro SAT_FLAG_EN):
//   - defined  : `sat` is a sticky flag.  It is set on the edge where either
//                accumulator would exceed its maximum, and is cleared by the
//                next accepted start or by reset.
//   - undefined: no overflow detection logic is built, and `sat` is tied to 0.
//
// Ports:
//   clk          in   single clock; all state changes on its rising edge
//   reset_L      in   asynchronous active-low reset
//   din          in   gate output Q under measurement
//   start        in   measurement request; accepted only in IDLE
//   window_len   in   [CNT_W]  sample edges per window; latched on accept
//   ack          in   consumer acknowledge; only honoured in REPORT
//   busy         out  high while measuring
//   valid        out  high while results are being reported (held stable)
//   toggle_count out  [CNT_W]  transitions counted in the last window
//   energy       out  [PWR_W]  weighted energy of the last window
//   sat          out  sticky saturation flag (0 unless SAT_FLAG_EN)
// -----------------------------------------------------------------------------
module nor_power_meter #(
    parameter int CNT_W  = 16,
    parameter int PWR_W  = 24,
    parameter int E_RISE = 3,
    parameter int E_FALL = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             din,
    input  logic             start,
    input  logic [CNT_W-1:0] window_len,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] toggle_count,
    output logic [PWR_W-1:0] energy,
    output logic             sat
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PWR_W-1:0] PWR_ZERO = {PWR_W{1'b0}};
    localparam logic [PWR_W-1:0] PWR_MAX  = {PWR_W{1'b1}};
    localparam logic [PWR_W-1:0] E_RISE_W = PWR_W'(E_RISE);
    localparam logic [PWR_W-1:0] E_FALL_W = PWR_W'(E_FALL);

    // Saturating increment of the toggle counter.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] a);
        logic [CNT_W-1:0] r;
        if (a == CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = a + CNT_ONE;
        end
        return r;
    endfunction

    // Saturating add on the energy accumulator (carry out means clamp).
    function automatic logic [PWR_W-1:0] pwr_sat_add(input logic [PWR_W-1:0] a,
                                                     input logic [PWR_W-1:0] inc);
        logic [PWR_W:0]   sum;
        logic [PWR_W-1:0] r;
        sum = {1'b0, a} + {1'b0, inc};
        if (sum[PWR_W]) begin
            r = PWR_MAX;
        end else begin
            r = sum[PWR_W-1:0];
        end
        return r;
    endfunction

`ifdef SAT_FLAG_EN
    // True when adding `inc` to `a` would exceed the energy maximum.
    function automatic logic pwr_would_ovf(input logic [PWR_W-1:0] a,
                                           input logic [PWR_W-1:0] inc);
        logic [PWR_W:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return sum[PWR_W];
    endfunction
`endif

    state_t           state_q, state_d;
    logic             din_q;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PWR_W-1:0] pwr_q, pwr_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             toggle_s;
    logic [PWR_W-1:0] inc_s;
`ifdef SAT_FLAG_EN
    logic             sat_q, sat_d;
`endif

    // Transition detection and the energy weight selected by its direction.
    always_comb begin
        toggle_s = (din != din_q);
        if (din) begin
            inc_s = E_RISE_W;
        end else begin
            inc_s = E_FALL_W;
        end
    end

    // Next-state and next-result computation for the measurement FSM.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        pwr_d       = pwr_q;
`ifdef SAT_FLAG_EN
        sat_d       = sat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d       = CNT_ZERO;
                    pwr_d       = PWR_ZERO;
`ifdef SAT_FLAG_EN
                    sat_d       = 1'b0;
`endif
                    remaining_d = window_len;
                    // A zero-length window reports empty results at once.
                    if (window_len == CNT_ZERO) begin
                        state_d = ST_REPORT;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                if (toggle_s) begin
                    cnt_d = cnt_sat_inc(cnt_q);
                    pwr_d = pwr_sat_add(pwr_q, inc_s);
`ifdef SAT_FLAG_EN
                    sat_d = sat_q | (cnt_q == CNT_MAX) | pwr_would_ovf(pwr_q, inc_s);
`endif
                end else begin
                    cnt_d = cnt_q;
                    pwr_d = pwr_q;
                end
                remaining_d = remaining_q - CNT_ONE;
                // The last sample edge still counts its own transition.
                // Treating 0 as "last" also protects against a corrupted count.
                if (remaining_q <= CNT_ONE) begin
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_MEASURE;
                end
            end
            ST_REPORT: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: begin
                // The unused encoding recovers to IDLE.
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d == ST_MEASURE);
        valid_d = (state_d == ST_REPORT);
    end

    // State, sample and result registers, cleared asynchronously by reset_L.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_IDLE;
            din_q       <= 1'b0;
            remaining_q <= CNT_ZERO;
            cnt_q       <= CNT_ZERO;
            pwr_q       <= PWR_ZERO;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
`ifdef SAT_FLAG_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            // Sampled in every state, so the first window edge compares
            // against a fresh value.
            din_q       <= din;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            pwr_q       <= pwr_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
`ifdef SAT_FLAG_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign valid        = valid_q;
    assign toggle_count = cnt_q;
    assign energy       = pwr_q;
`ifdef SAT_FLAG_EN
    assign sat          = sat_q;
`else
    assign sat          = 1'b0;
`endif

endmodule

// File: tb/tb_nor_power_meter.sv
// -----------------------------------------------------------------------------
// Testbench for nor_power_meter.
//
// The DUT is instantiated with narrow widths so that saturation can be reached
// in a short run.  Each measurement pre-computes its expected result from the
// transition rules and pushes it into a queue.  A negedge monitor pops an
// entry and compares it whenever valid rises, including the expected cycle
// at which valid should appear.
// -----------------------------------------------------------------------------
module tb_nor_power_meter;
    localparam int CNT_W  = 5;
    localparam int PWR_W  = 6;
    localparam int E_RISE = 3;
    localparam int E_FALL = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int PMAX   = (1 << PWR_W) - 1;

    logic             clk = 1'b0;
    logic             reset_L = 1'b0;
    logic             din = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] window_len = '0;
    logic             ack = 1'b0;
    logic             busy, valid, sat;
    logic [CNT_W-1:0] toggle_count;
    logic [PWR_W-1:0] energy;

    nor_power_meter #(.CNT_W(CNT_W), .PWR_W(PWR_W), .E_RISE(E_RISE), .E_FALL(E_FALL)) dut (
        .clk(clk), .reset_L(reset_L), .din(din), .start(start),
        .window_len(window_len), .ack(ack), .busy(busy), .valid(valid),
        .toggle_count(toggle_count), .energy(energy), .sat(sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cnt;
        int pwr;
        int s;
        int vcyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   last_cnt = 0, last_pwr = 0, last_sat = 0;
    bit   pat[64];
    bit   vprev = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one rising edge; inputs change 1 time unit after it.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_check();
        exp_t e;
        if (sbq.size() == 0) begin
            check("unexpected_valid", 1, 0);
        end else begin
            e = sbq.pop_front();
            check("toggle_count", int'(toggle_count), e.cnt);
            check("energy", int'(energy), e.pwr);
            check("sat", int'(sat), e.s);
            check("valid_latency_cycle", cyc, e.vcyc);
            check("busy_in_report", int'(busy), 0);
        end
    endtask

    // Monitor: compare against the scoreboard whenever valid rises.
    always @(negedge clk) begin
        if (valid && !vprev) mon_check();
        vprev <= valid;
    end

    // Run one window.
    //   mode 0: random din
    //   mode 1: din toggles on every sample edge
    //   mode 2: din taken from pat[]
    task automatic run_meas(input int len, input int mode);
        bit   d[64];
        int   p, cnt, sum, w;
        exp_t e;
        p = int'(din);           // din_q after the accept edge
        for (int i = 0; i < len; i++) begin
            if (mode == 0)      d[i] = 1'($urandom_range(0, 1));
            else if (mode == 1) d[i] = (i == 0) ? ~1'(p) : ~d[i-1];
            else                d[i] = pat[i];
        end
        cnt = 0;
        sum = 0;
        for (int i = 0; i < len; i++) begin
            if (int'(d[i]) != p) begin
                cnt++;
                sum += d[i] ? E_RISE : E_FALL;
            end
            p = int'(d[i]);
        end
        e.cnt = (cnt > CMAX) ? CMAX : cnt;
        e.pwr = (sum > PMAX) ? PMAX : sum;
`ifdef SAT_FLAG_EN
        e.s = (cnt > CMAX || sum > PMAX) ? 1 : 0;
`else
        e.s = 0;
`endif
        e.vcyc = cyc + 1 + len;
        sbq.push_back(e);
        last_cnt = e.cnt;
        last_pwr = e.pwr;
        last_sat = e.s;
        start = 1'b1;
        window_len = CNT_W'(len);
        adv();
        window_len = CNT_W'($urandom);   // changes after acceptance must not matter
        for (int i = 0; i < len; i++) begin
            start = 1'($urandom_range(0, 1));   // ignored while measuring
            din = d[i];
            if (i == 1) check("busy_in_measure", int'(busy), 1);
            adv();
        end
        start = 1'b0;
        w = 0;
        while (!valid && w < 5) begin
            adv();
            w++;
        end
        check("valid_reached", int'(valid), 1);
    endtask

    task automatic do_ack(input int hold);
        for (int i = 0; i < hold; i++) adv();
        ack = 1'b1;
        adv();
        ack = 1'b0;
        check("ack_clears_valid", int'(valid), 0);
        check("idle_not_busy", int'(busy), 0);
        check("idle_keeps_count", int'(toggle_count), last_cnt);
        check("idle_keeps_energy", int'(energy), last_pwr);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held while din toggles.
        for (int i = 0; i < 4; i++) begin
            din = ~din;
            adv();
            check("rst_busy", int'(busy), 0);
            check("rst_valid", int'(valid), 0);
            check("rst_count", int'(toggle_count), 0);
            check("rst_energy", int'(energy), 0);
            check("rst_sat", int'(sat), 0);
        end
        reset_L = 1'b1;
        adv();
        adv();
        check("post_rst_valid", int'(valid), 0);
        check("post_rst_busy", int'(busy), 0);

        // Four-phase NOR pattern: 1,0,0,0,0,1,0,0 from din_q=0 -> 4 toggles, energy 10.
        din = 1'b0;
        adv();
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 0;
        pat[4] = 0; pat[5] = 1; pat[6] = 0; pat[7] = 0;
        run_meas(8, 2);
        check("nor_pattern_count", int'(toggle_count), 4);
        check("nor_pattern_energy", int'(energy), 10);
        do_ack(2);

        // Zero-length window.
        run_meas(0, 0);
        check("zero_window_count", int'(toggle_count), 0);
        do_ack(0);

        // Back-pressure: results held while din toggles and start pulses.
        din = 1'b0;
        adv();
        run_meas(6, 1);
        for (int i = 0; i < 20; i++) begin
            din = ~din;
            start = 1'($urandom_range(0, 1));
            adv();
            check("bp_valid", int'(valid), 1);
            check("bp_busy", int'(busy), 0);
            check("bp_count", int'(toggle_count), last_cnt);
            check("bp_energy", int'(energy), last_pwr);
        end
        start = 1'b1;
        ack = 1'b1;
        adv();
        start = 1'b0;
        ack = 1'b0;
        check("start_ack_valid", int'(valid), 0);
        check("start_ack_busy", int'(busy), 0);
        adv();
        check("start_not_queued", int'(busy), 0);

        // Toggling windows: 15 edges fit (energy 38), 31 edges saturate energy.
        din = 1'b0;
        adv();
        run_meas(15, 1);
        check("tog15_count", int'(toggle_count), 15);
        check("tog15_energy", int'(energy), 38);
        do_ack(1);
        din = 1'b0;
        adv();
        run_meas(31, 1);
        check("tog31_count", int'(toggle_count), 31);
        check("tog31_energy", int'(energy), PMAX);
        do_ack(1);

        // Reset after 3 of 10 edges discards the window.
        din = 1'b0;
        start = 1'b1;
        window_len = CNT_W'(10);
        adv();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = ~din;
            adv();
        end
        reset_L = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_count", int'(toggle_count), 0);
        check("midrst_energy", int'(energy), 0);
        adv();
        reset_L = 1'b1;
        din = 1'b0;
        adv();
        pat[0] = 1; pat[1] = 1;
        run_meas(2, 2);
        check("after_rst_count", int'(toggle_count), 1);
        do_ack(1);

        // Random windows.
        for (int n = 0; n < 25; n++) begin
            din = 1'($urandom_range(0, 1));
            adv();
            run_meas($urandom_range(0, CMAX), 0);
            do_ack($urandom_range(0, 3));
        end

        adv();
        check("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
